mul_layer_pipe: RTL

MUL_LAYER_PIPE -- requirements
Module: mul_layer_pipe

---
 rtl/pudiannao_pkg.sv | 14 +
 rtl/mul_lane.sv | 65 ++++++
 rtl/mul_layer_pipe.sv | 74 +++++++
 3 files changed

// File: rtl/pudiannao_pkg.sv
// Shared types and default sizing for the pudiannao multiply layer.
package pudiannao_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = 16;

  typedef enum logic [1:0] {
    MODE_PP = 2'd0,
    MODE_HC = 2'd1,
    MODE_HP = 2'd2,
    MODE_PC = 2'd3
  } mode_e;

endpackage

// File: rtl/mul_lane.sv
// One multiply lane: operand select, product pipeline, saturate/truncate output stage.
// Stage advance is decided centrally; ld[k] loads stage k of this lane.
module mul_lane
  import pudiannao_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  hot,
  input  logic [WIDTH-1:0]  cold,
  input  logic [WIDTH-1:0]  pre,
  input  logic              en,
  input  logic [STAGES-1:0] ld,
  output logic [WIDTH-1:0]  out,
  output logic              sat_flag
);

  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] prod_in, last_prod;
  logic               hi_nz;

  always_comb begin
    op_a = pre;
    op_b = pre;
    case (mode_e'(mode))
      MODE_HC: begin op_a = hot; op_b = cold; end
      MODE_HP: begin op_a = hot; op_b = pre;  end
      MODE_PC: begin op_a = pre; op_b = cold; end
      default: begin op_a = pre; op_b = pre;  end
    endcase
  end

  // A disabled lane carries a zero product, so it leaves with out=0 and no flag.
  assign prod_in = en ? ({{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b}) : '0;

  if (STAGES == 1) begin : g_direct
    assign last_prod = prod_in;
  end else begin : g_pipe
    logic [2*WIDTH-1:0] p [STAGES-1];
    always_ff @(posedge clk) begin
      if (ld[0]) p[0] <= prod_in;
      for (int k = 1; k < STAGES-1; k++) begin
        if (ld[k]) p[k] <= p[k-1];
      end
    end
    assign last_prod = p[STAGES-2];
  end

  assign hi_nz = |last_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      sat_flag <= 1'b0;
    end else if (ld[STAGES-1]) begin
      sat_flag <= hi_nz;
      out      <= (SAT != 0 && hi_nz) ? '1 : last_prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_layer_pipe.sv
// Multi-lane unsigned multiply layer with a shared valid/ready pipeline.
// Stage k accepts when it is empty or its content moves on; the last stage moves on out_ready.
module mul_layer_pipe
  import pudiannao_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LANES  = DEF_LANES,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   mode,
  input  logic [LANES-1:0][WIDTH-1:0]  hot_in,
  input  logic [LANES-1:0][WIDTH-1:0]  cold_in,
  input  logic [LANES-1:0][WIDTH-1:0]  pre_data,
  input  logic [LANES-1:0]             lane_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  out,
  output logic [LANES-1:0]             sat_flag,
  output logic [15:0]                  done_cnt
);

  logic [STAGES-1:0] v, vin, take, ld;

  always_comb begin : ctl
    logic t;
    t    = out_ready;
    take = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      t       = !v[k] || t;
      take[k] = t;
    end
  end

  // Valid feeding each stage: in_valid for stage 0, the previous stage's valid otherwise.
  assign vin       = STAGES'({v, in_valid});
  assign ld        = take & vin;
  assign in_ready  = take[0];
  assign out_valid = v[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v        <= '0;
      done_cnt <= '0;
    end else begin
      v <= ld | (v & ~take);
      if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mul_lane #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .SAT    (SAT)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .hot      (hot_in[i]),
      .cold     (cold_in[i]),
      .pre      (pre_data[i]),
      .en       (lane_en[i]),
      .ld       (ld),
      .out      (out[i]),
      .sat_flag (sat_flag[i])
    );
  end

endmodule
